seg7_scan_driver: RTL and testbench

- Parametrised multiplexed driver for a DIGITS-wide common-enable 7-segment display.
- Holds a loaded value and time-multiplexes one digit at a time, for DIGITS × REFRESH_DIV cycles per full scan.
- Adds behaviour the single-digit combinational decoder lacks: BCD/hex mode, leading-zero suppression, per-digit decimal points and a refresh scan counter.
- Sits between the datapath and the board's SEG/AN pins.

---
 rtl/seg7_scan_driver.sv | 130 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed DIGITS-wide 7-segment scan driver with BCD/hex glyphs,
// leading-zero suppression, per-digit decimal points and registered outputs.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   VALUE,
  input  logic [DIGITS-1:0]     DP,
  input  logic                  HEX,
  input  logic                  LZS,
  output logic [6:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  DPO
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*DIGITS-1:0]   r_val;
  logic [DIGITS-1:0]     r_dpr;
  logic                  r_primed;
  logic [6:0]            r_seg;
  logic [DIGITS-1:0]     r_an;
  logic                  r_dpo;

  logic [3:0]            w_nib;
  logic [DIGITS-1:0]     w_an;
  logic [DIGITS-1:0]     w_lead_zero;
  logic                  w_zero_run;
  logic                  w_dp;
  logic                  w_blank;
  logic [6:0]            w_seg;

  function automatic logic [6:0] glyph(input logic [3:0] n, input logic hex);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    if (!hex && n > 4'd9) g = 7'b0000001;
    return g;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_nib       = '0;
    w_an        = '0;
    w_dp        = 1'b0;
    w_lead_zero = '0;
    w_zero_run  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib   = r_val[4*i +: 4];
        w_an[i] = 1'b1;
        w_dp    = r_dpr[i];
      end
    end
    // Digit i is a leading zero when it and every higher nibble are zero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_run     = w_zero_run & (r_val[4*i +: 4] == 4'd0);
      w_lead_zero[i] = w_zero_run;
    end
    w_blank = LZS && (r_idx != '0) && ((w_lead_zero & w_an) != '0);
    w_seg   = w_blank ? 7'b0000000 : glyph(w_nib, HEX);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_val    <= '0;
      r_dpr    <= '0;
      r_primed <= 1'b0;
      r_seg    <= '0;
      r_an     <= '0;
      r_dpo    <= 1'b0;
    end else begin
      r_primed <= 1'b1;
      if (LOAD) begin
        r_val <= VALUE;
        r_dpr <= DP;
      end
      // The first edge out of reset only primes the outputs; the scan starts
      // counting afterwards so digit 0 gets its full dwell time.
      if (r_primed) begin
        if (r_cnt == CNT_LAST) begin
          r_cnt <= '0;
          r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        r_seg <= w_seg;
        r_an  <= w_an;
        r_dpo <= w_dp;
      end else begin
        r_seg <= '0;
        r_an  <= '0;
        r_dpo <= 1'b0;
      end
    end
  end

  assign SEG = r_seg;
  assign AN  = r_an;
  assign DPO = r_dpo;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (DIGITS=4, REFRESH_DIV=4): a cycle-count
// reference model queues expected outputs, a monitor pops and compares each cycle.
module tb_seg7_scan_driver;

  localparam int DIGITS = 4;
  localparam int RDIV   = 4;

  logic        clk = 1'b0;
  logic        rst, load, hex, lzs;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dpo;

  seg7_scan_driver #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV)) dut (
    .CLK(clk), .RST(rst), .LOAD(load), .VALUE(value), .DP(dp),
    .HEX(hex), .LZS(lzs), .SEG(seg), .AN(an), .DPO(dpo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       dpo;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   done     = 1'b0;

  // Reference model state: edges since reset release and the loaded copies.
  int          k = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp  = '0;

  logic [6:0] glyph_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  // Visible digit after k edges: edge 1 is blank, then each digit holds RDIV edges.
  function automatic int digit_at(input int kk);
    return ((kk - 2) / RDIV) % DIGITS;
  endfunction

  // Predict the outputs for the coming edge from the current inputs, then advance a cycle.
  task automatic tick();
    exp_t e;
    int   d;
    int   n;
    e = '0;
    if (rst) begin
      k = 0; m_val = '0; m_dp = '0;
    end else begin
      k++;
      if (k >= 2) begin
        d     = digit_at(k);
        n     = int'((m_val >> (4 * d)) & 16'hF);
        e.an  = 4'(1 << d);
        e.dpo = m_dp[d];
        if (lzs && d > 0 && (m_val >> (4 * d)) == 16'd0) e.seg = 7'b0000000;
        else if (!hex && n > 9)                           e.seg = 7'b0000001;
        else                                               e.seg = glyph_tab[n];
      end
      if (load) begin
        m_val = value; m_dp = dp;
      end
    end
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p);
    value = v; dp = p; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Monitor: outputs are registered, so compare shortly after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!done && q.size() > 0) begin
      e = q.pop_front();
      check("SEG", int'(seg), int'(e.seg));
      check("AN",  int'(an),  int'(e.an));
      check("DPO", int'(dpo), int'(e.dpo));
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; hex = 1'b0; lzs = 1'b0; value = '0; dp = '0;

    // 1. Reset then scan
    run(2);
    rst = 1'b0;
    run(24);

    // 2. BCD decode
    do_load(16'h1234, 4'b0000);
    run(18);

    // 3. Hex vs BCD, HEX switched live
    hex = 1'b1;
    do_load(16'hAF0C, 4'b0000);
    run(18);
    hex = 1'b0;
    run(18);

    // 4. Leading-zero suppression
    lzs = 1'b1;
    do_load(16'h0050, 4'b0000);
    run(18);
    do_load(16'h0000, 4'b0000);
    run(18);
    hex = 1'b1;
    do_load(16'h00A0, 4'b0001);
    run(18);
    lzs = 1'b0; hex = 1'b0;

    // 5. DP and LOAD coinciding with an idx advance
    do_load(16'h9876, 4'b0100);
    while (!(k >= 4 && k % RDIV == 0)) tick();
    do_load(16'h4321, 4'b0100);
    run(18);

    // 6. Mid-scan reset while digit 2 is shown
    while (!(k >= 2 && digit_at(k) == 2)) tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(10);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      for (int j = 0; j < 4; j++) if ($urandom_range(1, 0) == 0) v[4*j +: 4] = 4'h0;
      if ($urandom_range(15, 0) == 0) hex = ~hex;
      if ($urandom_range(15, 0) == 0) lzs = ~lzs;
      rst   = ($urandom_range(99, 0) == 0);
      load  = ($urandom_range(7, 0) == 0);
      value = v;
      dp    = 4'($urandom);
      tick();
    end
    rst = 1'b0; load = 1'b0;
    run(3);

    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
